obstacle_scheduler: RTL and testbench

Decides when the next obstacle enters the Dino playfield and what kind it is. It sits directly downstream of the 8-bit LFSR random source. It samples one random byte per obstacle and requests the next byte with a single-cycle advance pulse. It counts a randomised number of game frames, then offers a spawn request to the obstacle renderer over a valid/ready handshake.

---
 rtl/obstacle_scheduler_pkg.sv | 33 +++
 rtl/obstacle_gap_counter.sv | 37 +++
 rtl/obstacle_scheduler.sv | 93 +++++++++
 tb/tb_obstacle_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_scheduler_pkg.sv
// rtl/obstacle_scheduler_pkg.sv - shared types and constants for the obstacle scheduler
//
// Holds the scheduler state encoding, the gap counter width, the obstacle
// type codes shared with the renderer, and the gap calculation.
package obstacle_scheduler_pkg;

    localparam int GAP_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SPAWN = 2'd3
    } sched_state_t;

    typedef enum logic [1:0] {
        OBST_CACTUS_SMALL = 2'd0,
        OBST_CACTUS_LARGE = 2'd1,
        OBST_BIRD_LOW     = 2'd2,
        OBST_BIRD_HIGH    = 2'd3
    } obstacle_t;

    // Frames until the next spawn: base spacing shrunk by difficulty plus
    // up to 31 frames of random jitter.
    function automatic logic [GAP_W-1:0] calc_gap(input int min_gap, input int speed_step,
                                                  input logic [1:0] speed,
                                                  input logic [4:0] jitter);
        int gap;
        gap = min_gap - speed_step * int'(speed) + int'(jitter);
        return GAP_W'(gap);
    endfunction

endpackage

// File: rtl/obstacle_gap_counter.sv
// rtl/obstacle_gap_counter.sv - loadable down-counter measuring frames between obstacles
//
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   load/value  load the counter with a new gap
//   tick        count one frame (decrements while non-zero)
//   clear       force the counter to zero; wins over load and tick
//   expire      tick arriving while the count is 1
module obstacle_gap_counter
    import obstacle_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [GAP_W-1:0] value,
    input  logic             tick,
    input  logic             clear,
    output logic             expire
);

    logic [GAP_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (tick && (count != '0)) begin
            count <= count - GAP_W'(1);
        end
    end

    assign expire = tick && (count == GAP_W'(1));

endmodule

// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - paces obstacle spawns from LFSR bytes and game frames
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   frame_tick   one-cycle pulse per game frame
//   run          game active; low drops everything back to IDLE
//   speed        difficulty 0..3, sampled in LOAD
//   rand_in      LFSR byte, sampled in LOAD
//   rand_next    advances the LFSR (high during LOAD)
//   spawn_valid / spawn_ready / spawn_type   spawn handshake to the renderer
//   spawn_count  accepted spawns since reset, saturating at 255
module obstacle_scheduler
    import obstacle_scheduler_pkg::*;
#(
    parameter int MIN_GAP    = 20,
    parameter int SPEED_STEP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       run,
    input  logic [1:0] speed,
    input  logic [7:0] rand_in,
    output logic       rand_next,
    output logic       spawn_valid,
    input  logic       spawn_ready,
    output logic [1:0] spawn_type,
    output logic [7:0] spawn_count
);

    sched_state_t     state, next_state;
    obstacle_t        type_q;
    logic [GAP_W-1:0] gap_value;
    logic             gap_expire;
    logic             accept;
    logic             rand_unused_bit;

    // Bit 5 of the LFSR byte is neither jitter nor type.
    assign rand_unused_bit = rand_in[5];

    assign gap_value = calc_gap(MIN_GAP, SPEED_STEP, speed, rand_in[4:0]);
    assign accept    = (state == ST_SPAWN) && spawn_ready && run;

    obstacle_gap_counter u_gap (
        .clk    (clk),
        .reset  (reset),
        .load   (state == ST_LOAD),
        .value  (gap_value),
        .tick   (frame_tick && (state == ST_WAIT)),
        .clear  (!run),
        .expire (gap_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            type_q      <= OBST_CACTUS_SMALL;
            spawn_count <= '0;
        end else begin
            state <= next_state;
            if (state == ST_LOAD) begin
                type_q <= obstacle_t'(rand_in[7:6]);
            end
            if (accept && (spawn_count != 8'hFF)) begin
                spawn_count <= spawn_count + 8'd1;
            end
        end
    end

    always_comb begin
        next_state  = state;
        rand_next   = 1'b0;
        spawn_valid = 1'b0;
        spawn_type  = OBST_CACTUS_SMALL;
        case (state)
            ST_IDLE:  if (run) next_state = ST_LOAD;
            ST_LOAD: begin
                rand_next  = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT:  if (gap_expire) next_state = ST_SPAWN;
            ST_SPAWN: begin
                spawn_valid = 1'b1;
                spawn_type  = type_q;
                if (spawn_ready) next_state = ST_LOAD;
            end
            default:  next_state = ST_IDLE;
        endcase
        // Stopping the game abandons any gap or pending spawn.
        if (!run) next_state = ST_IDLE;
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - self-checking bench for obstacle_scheduler
module tb_obstacle_scheduler;

    localparam int MIN_GAP    = 20;
    localparam int SPEED_STEP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       run;
    logic [1:0] speed;
    logic [7:0] rand_in;
    logic       rand_next;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [1:0] spawn_type;
    logic [7:0] spawn_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int typ;
        int gap;
    } exp_t;

    exp_t sb[$];
    int   mon_ticks   = 0;
    int   last_ticks  = 0;
    int   exp_count   = 0;
    int   held_type   = 0;
    bit   armed       = 0;
    bit   in_spawn    = 0;
    bit   expect_load = 0;

    obstacle_scheduler #(.MIN_GAP(MIN_GAP), .SPEED_STEP(SPEED_STEP)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .run         (run),
        .speed       (speed),
        .rand_in     (rand_in),
        .rand_next   (rand_next),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_type  (spawn_type),
        .spawn_count (spawn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: samples mid-cycle, pushes expectations on LOAD,
    // compares on the rising edge of spawn_valid and after each accept.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            armed       = 0;
            in_spawn    = 0;
            expect_load = 0;
            exp_count   = 0;
        end else begin
            if (expect_load) begin
                check("acc_rand_next", rand_next, 1);
                check("acc_valid_low", spawn_valid, 0);
                check("acc_count", spawn_count, exp_count);
                expect_load = 0;
            end
            if (!run) begin
                sb.delete();
                armed    = 0;
                in_spawn = 0;
            end else if (rand_next) begin
                sb.push_back('{typ: int'(rand_in[7:6]),
                               gap: MIN_GAP - SPEED_STEP * int'(speed) + int'(rand_in[4:0])});
                armed     = 1;
                mon_ticks = 0;
            end else if (spawn_valid) begin
                if (!in_spawn) begin
                    check("sb_nonempty", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("spawn_type", spawn_type, e.typ);
                        check("gap_ticks", mon_ticks, e.gap);
                    end
                    last_ticks = mon_ticks;
                    held_type  = spawn_type;
                    in_spawn   = 1;
                end else begin
                    check("type_hold", spawn_type, held_type);
                end
                if (spawn_ready) begin
                    if (exp_count < 255) exp_count++;
                    expect_load = 1;
                    in_spawn    = 0;
                    armed       = 0;
                end
            end else if (armed && frame_tick) begin
                mon_ticks++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rand_next) begin
                ok = 1;
                break;
            end
        end
        check("load_seen", ok, 1);
    endtask

    task automatic tick_until_spawn(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (spawn_valid) break;
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            rand_in    = 8'($urandom);
            speed      = 2'($urandom);
            step();
        end
        check("spawn_seen", spawn_valid, 1);
    endtask

    initial begin
        int accepts;
        reset       = 1'b1;
        run         = 1'b0;
        frame_tick  = 1'b0;
        speed       = 2'd0;
        rand_in     = 8'd0;
        spawn_ready = 1'b0;

        // Reset and idle with noise on every input but run.
        for (int i = 0; i < 12; i++) begin
            if (i == 4) reset = 1'b0;
            frame_tick  = 1'($urandom);
            speed       = 2'($urandom);
            rand_in     = 8'($urandom);
            spawn_ready = 1'($urandom);
            step();
            check("idle_rand_next", rand_next, 0);
            check("idle_valid", spawn_valid, 0);
            check("idle_type", spawn_type, 0);
            check("idle_count", spawn_count, 0);
        end
        frame_tick  = 1'b0;
        spawn_ready = 1'b0;

        // speed 0, byte C5: gap 25, bird high.
        speed   = 2'd0;
        rand_in = 8'hC5;
        run     = 1'b1;
        wait_load();
        step();
        check("c5_wait_rand_next", rand_next, 0);
        rand_in = 8'($urandom);
        tick_until_spawn(60);
        check("c5_ticks", last_ticks, 25);
        check("c5_type", spawn_type, 3);

        // Renderer stalls; frame ticks must not disturb the pending spawn.
        for (int i = 0; i < 10; i++) begin
            frame_tick = (i % 2 == 0);
            step();
            check("stall_valid", spawn_valid, 1);
            check("stall_type", spawn_type, 3);
        end
        frame_tick  = 1'b0;
        speed       = 2'd3;
        rand_in     = 8'h00;
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
        check("first_accept_count", spawn_count, 1);
        step();
        rand_in = 8'($urandom);
        tick_until_spawn(60);
        check("s3_ticks", last_ticks, 8);
        check("s3_type", spawn_type, 0);

        // Drop run with a spawn pending.
        run = 1'b0;
        step();
        check("drop_valid", spawn_valid, 0);
        check("drop_count", spawn_count, 1);
        step();
        rand_in = 8'h9A;
        speed   = 2'd1;
        run     = 1'b1;
        wait_load();
        step();
        rand_in = 8'($urandom);
        tick_until_spawn(80);
        check("rerun_ticks", last_ticks, 42);
        check("rerun_type", spawn_type, 2);
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
        check("rerun_count", spawn_count, 2);

        // Back-to-back spawns with ready tied high until saturation.
        spawn_ready = 1'b1;
        frame_tick  = 1'b1;
        accepts     = 0;
        for (int i = 0; i < 20000 && accepts < 260; i++) begin
            if (spawn_valid) accepts++;
            rand_in = 8'($urandom);
            speed   = 2'($urandom);
            step();
        end
        check("b2b_accepts", accepts, 260);
        check("sat_count", spawn_count, 255);
        spawn_ready = 1'b0;
        frame_tick  = 1'b0;
        step();
        check("pre_reset_wait_valid", spawn_valid, 0);
        check("pre_reset_count", spawn_count, 255);

        // Asynchronous reset mid-WAIT, observed before any clock edge.
        #2;
        reset = 1'b1;
        #1;
        check("async_count", spawn_count, 0);
        check("async_valid", spawn_valid, 0);
        check("async_rand_next", rand_next, 0);
        check("async_type", spawn_type, 0);
        run = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        check("post_reset_rand_next", rand_next, 0);
        check("post_reset_count", spawn_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
